// File: rtl/dmem_access_unit.sv
// Load/store front end for a 256x32 single-port block RAM with a 1-cycle synchronous read.
// Byte and halfword stores are done as read-modify-write; loads are lane-extracted and extended.
module dmem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              ack,
  output logic              err,
  output logic [31:0]       rdata,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-3:0] ram_ad,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout,
  output logic              ram_reset
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WRITE, DONE} state_t;

  state_t            state, state_nxt;
  logic              we_q, sext_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       store_q;
  logic [31:0]       rdata_q;
  logic              req_bad;
  logic [31:0]       load_val;
  logic [31:0]       merged;
  logic [31:0]       lane_shift;

  assign req_bad = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_bad)                     state_nxt = DONE;
          else if (we && size == 2'b10)    state_nxt = WRITE;
          else                             state_nxt = READ;
        end
      end
      READ:    state_nxt = CAPT;
      CAPT:    state_nxt = we_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // store_q starts as the store data and becomes the merged word in CAPT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      store_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q    <= we;
            sext_q  <= sext;
            err_q   <= req_bad;
            size_q  <= size;
            addr_q  <= addr;
            store_q <= wdata;
          end
        end
        CAPT: begin
          if (we_q) store_q <= merged;
          else      rdata_q <= load_val;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_shift = ram_dout >> {addr_q[1:0], 3'b000};
    load_val   = ram_dout;
    merged     = ram_dout;
    case (size_q)
      2'b00: begin
        load_val = {{24{sext_q & lane_shift[7]}}, lane_shift[7:0]};
        merged[{addr_q[1:0], 3'b000} +: 8] = store_q[7:0];
      end
      2'b01: begin
        load_val = {{16{sext_q & lane_shift[15]}}, lane_shift[15:0]};
        merged[{addr_q[1], 4'b0000} +: 16] = store_q[15:0];
      end
      default: ;
    endcase
  end

  assign ready     = (state == IDLE);
  assign ack       = (state == DONE);
  assign err       = ack & err_q;
  assign rdata     = rdata_q;
  assign ram_ce    = (state == READ) || (state == WRITE);
  assign ram_wre   = (state == WRITE);
  assign ram_oce   = 1'b1;
  assign ram_ad    = addr_q[ADDR_W-1:2];
  assign ram_din   = store_q;
  assign ram_reset = reset;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: a behavioural RAM plus a byte-array reference model of memory
// contents, directed scenarios followed by randomized loads and stores.
module tb_dmem_access_unit;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req = 1'b0;
  logic              we = 1'b0;
  logic [1:0]        size = 2'b00;
  logic              sext = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic              ready, ack, err;
  logic [31:0]       rdata;
  logic              ram_ce, ram_oce, ram_wre, ram_reset;
  logic [ADDR_W-3:0] ram_ad;
  logic [31:0]       ram_din, ram_dout;

  logic              clear_ram = 1'b1;
  logic [31:0]       ram_mem [256];
  logic [31:0]       ram_q;

  logic [7:0]        ref_mem [1024];
  logic [31:0]       exp_hold;
  int                n_cmp = 0;
  int                n_err = 0;

  dmem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .ready(ready), .ack(ack), .err(err), .rdata(rdata),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_reset(ram_reset)
  );

  always #5 clk = ~clk;

  // block RAM: synchronous read, write-through on the output register
  always @(posedge clk) begin
    if (clear_ram) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
      ram_q <= '0;
    end else if (ram_ce) begin
      if (ram_wre) begin
        ram_mem[ram_ad] <= ram_din;
        ram_q           <= ram_din;
      end else begin
        ram_q <= ram_mem[ram_ad];
      end
    end
  end
  assign ram_dout = ram_q;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic is_bad(input logic [1:0] sz, input logic [ADDR_W-1:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                             input logic [ADDR_W-1:0] a);
    logic [31:0] v;
    int n;
    v = 0;
    n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[int'(a) + i]) << (8 * i));
    if (sx && n == 1 && v >= 32'd128)   v = v - 32'd256;
    if (sx && n == 2 && v >= 32'd32768) v = v - 32'd65536;
    return v;
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [ADDR_W-1:0] a,
                             input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready_before_req", 32'(ready), 32'd1);
  endtask

  // counts edges from the accept edge (inclusive) until ack is seen, sampled 1 time unit after each edge
  task automatic wait_ack(output int lat, output logic ce_seen);
    lat = 1;
    ce_seen = ram_ce;
    while (!ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      ce_seen = ce_seen | ram_ce;
    end
    checkOutput("ack_seen", 32'(ack), 32'd1);
  endtask

  task automatic applyStimulus(input logic w, input logic [1:0] sz, input logic sx,
                               input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                               output logic [31:0] got_rdata);
    int   lat, exp_lat;
    logic ce_seen, bad;
    bad     = is_bad(sz, a);
    exp_lat = bad ? 1 : (!w ? 3 : (sz == 2'd2 ? 2 : 4));
    wait_ready();
    we = w; size = sz; sext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    we = 1'($urandom); size = 2'($urandom); sext = 1'($urandom);
    addr = ADDR_W'($urandom); wdata = $urandom;
    wait_ack(lat, ce_seen);
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("err", 32'(err), 32'(bad));
    if (bad) checkOutput("no_ram_on_err", 32'(ce_seen), 32'd0);
    if (!bad) begin
      if (w) model_store(sz, a, wd);
      else   exp_hold = model_load(sz, sx, a);
    end
    checkOutput("rdata", rdata, exp_hold);
    got_rdata = rdata;
  endtask

  initial begin
    logic [31:0] got;
    int          lat, extra;
    logic        ce_seen;
    logic        rw, rsx;
    logic [1:0]  rsz;
    logic [ADDR_W-1:0] ra;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    exp_hold = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_rdata", rdata, 32'h0);
    checkOutput("rst_ram_ce", 32'(ram_ce), 32'd0);
    checkOutput("rst_ram_wre", 32'(ram_wre), 32'd0);
    checkOutput("rst_ram_ad", 32'(ram_ad), 32'd0);
    checkOutput("rst_ram_din", ram_din, 32'h0);
    checkOutput("rst_ram_oce", 32'(ram_oce), 32'd1);
    checkOutput("rst_ram_reset", 32'(ram_reset), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    clear_ram = 1'b0;
    #1;
    checkOutput("ram_reset_low", 32'(ram_reset), 32'd0);

    $display("[TB] directed scenarios");
    applyStimulus(1'b1, 2'd2, 1'b0, 10'h010, 32'h11223344, got);
    applyStimulus(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, got);
    checkOutput("tp_word_load", got, 32'h11223344);
    applyStimulus(1'b1, 2'd0, 1'b0, 10'h012, 32'h000000AA, got);
    applyStimulus(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, got);
    checkOutput("tp_byte_merge", got, 32'h11AA3344);
    applyStimulus(1'b0, 2'd0, 1'b1, 10'h012, 32'h0, got);
    checkOutput("tp_sbyte", got, 32'hFFFFFFAA);
    applyStimulus(1'b0, 2'd0, 1'b0, 10'h012, 32'h0, got);
    checkOutput("tp_ubyte", got, 32'h000000AA);
    applyStimulus(1'b1, 2'd1, 1'b0, 10'h010, 32'h00008001, got);
    applyStimulus(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, got);
    checkOutput("tp_half_merge", got, 32'h11AA8001);
    applyStimulus(1'b0, 2'd1, 1'b1, 10'h010, 32'h0, got);
    checkOutput("tp_shalf", got, 32'hFFFF8001);
    applyStimulus(1'b0, 2'd1, 1'b0, 10'h012, 32'h0, got);
    checkOutput("tp_uhalf", got, 32'h000011AA);
    applyStimulus(1'b0, 2'd1, 1'b0, 10'h011, 32'h0, got);
    applyStimulus(1'b1, 2'd2, 1'b0, 10'h012, 32'hDEADBEEF, got);
    applyStimulus(1'b0, 2'd3, 1'b0, 10'h010, 32'h0, got);
    applyStimulus(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, got);
    checkOutput("tp_err_no_change", got, 32'h11AA8001);
    applyStimulus(1'b1, 2'd2, 1'b0, 10'h014, 32'hCAFEF00D, got);

    $display("[TB] req held high across two loads");
    wait_ready();
    we = 1'b0; size = 2'd2; sext = 1'b0; addr = 10'h010; req = 1'b1;
    @(posedge clk); #1;
    addr = 10'h014;
    wait_ack(lat, ce_seen);
    checkOutput("b2b_lat1", 32'(lat), 32'd3);
    checkOutput("b2b_data1", rdata, 32'h11AA8001);
    @(posedge clk); #1;
    checkOutput("b2b_idle_ready", 32'(ready), 32'd1);
    checkOutput("b2b_idle_ack", 32'(ack), 32'd0);
    @(posedge clk); #1;
    checkOutput("b2b_accepted", 32'(ready), 32'd0);
    req = 1'b0;
    wait_ack(lat, ce_seen);
    checkOutput("b2b_lat2", 32'(lat), 32'd3);
    checkOutput("b2b_data2", rdata, 32'hCAFEF00D);
    exp_hold = 32'hCAFEF00D;
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack) extra++;
    end
    checkOutput("b2b_no_dup", 32'(extra), 32'd0);

    $display("[TB] reset during WRITE of a byte store");
    wait_ready();
    we = 1'b1; size = 2'd0; sext = 1'b0; addr = 10'h013; wdata = 32'h00000055; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1;
    while (!ram_wre && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("abort_reached_write", 32'(ram_wre), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_wre", 32'(ram_wre), 32'd0);
    checkOutput("abort_ce", 32'(ram_ce), 32'd0);
    checkOutput("abort_ack", 32'(ack), 32'd0);
    checkOutput("abort_ready", 32'(ready), 32'd1);
    #2;
    reset = 1'b0;
    exp_hold = 32'h0;
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (ack) extra++;
    end
    checkOutput("abort_no_ack", 32'(extra), 32'd0);
    applyStimulus(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, got);
    checkOutput("abort_word_kept", got, 32'h11AA8001);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 300; k++) begin
      rw  = 1'($urandom);
      rsz = 2'($urandom_range(0, 3));
      rsx = 1'($urandom);
      ra  = ADDR_W'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'd1) ra[0] = 1'b0;
        if (rsz == 2'd2) ra[1:0] = 2'b00;
      end
      applyStimulus(rw, rsz, rsx, ra, $urandom, got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
